// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the SRAM arbiter and its round-robin selector.
package sram_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ACK,
    RELEASE
  } state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request bit above last_grant, wrapping.
module rr_select #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [IDX_W-1:0]     last_grant,
  output logic                 valid,
  output logic [IDX_W-1:0]     winner
);

  logic [2*NUM_PORTS-1:0] doubled;
  logic [2*NUM_PORTS-1:0] mask;
  logic [2*NUM_PORTS-1:0] masked;
  logic                   found;

  assign doubled = {request, request};
  assign masked  = doubled & mask;
  assign valid   = |request;

  // The upper copy is never masked, so any set request is always found there.
  always_comb begin
    mask = '0;
    for (int i = 0; i < 2 * NUM_PORTS; i++) begin
      mask[i] = (i > int'(last_grant));
    end
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < 2 * NUM_PORTS; i++) begin
      if (masked[i] && !found) begin
        found  = 1'b1;
        winner = (i >= NUM_PORTS) ? IDX_W'(i - NUM_PORTS) : IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM_interface among NUM_PORTS level-handshake requesters.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  parameter  int ADDR_W    = DEFAULT_ADDR_W,
  parameter  int DATA_W    = DEFAULT_DATA_W,
  localparam int GRANT_W   = $clog2(NUM_PORTS)
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NUM_PORTS-1:0]        i_request,
  input  logic [NUM_PORTS-1:0]        i_rw,
  input  logic [NUM_PORTS*ADDR_W-1:0] i_address,
  input  logic [NUM_PORTS*DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0]           o_rdata,
  output logic [NUM_PORTS-1:0]        o_ready,
  output logic                        o_sram_request,
  output logic                        o_sram_rw,
  output logic [ADDR_W-1:0]           o_sram_address,
  output logic [DATA_W-1:0]           o_sram_wdata,
  input  logic [DATA_W-1:0]           i_sram_rdata,
  input  logic                        i_sram_ready,
  output logic [GRANT_W-1:0]          o_grant,
  output logic                        o_busy
);

  state_t             state;
  logic [GRANT_W-1:0] last_grant;
  logic               sel_valid;
  logic [GRANT_W-1:0] sel_winner;

  rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (GRANT_W)
  ) u_rr_select (
    .request    (i_request),
    .last_grant (last_grant),
    .valid      (sel_valid),
    .winner     (sel_winner)
  );

  // o_grant doubles as the owner index for the rest of the transaction.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      last_grant     <= GRANT_W'(NUM_PORTS - 1);
      o_rdata        <= '0;
      o_ready        <= '0;
      o_sram_request <= 1'b0;
      o_sram_rw      <= 1'b0;
      o_sram_address <= '0;
      o_sram_wdata   <= '0;
      o_grant        <= '0;
      o_busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            o_sram_rw      <= i_rw[sel_winner];
            o_sram_address <= i_address[int'(sel_winner)*ADDR_W +: ADDR_W];
            o_sram_wdata   <= i_wdata[int'(sel_winner)*DATA_W +: DATA_W];
            o_sram_request <= 1'b1;
            o_grant        <= sel_winner;
            o_busy         <= 1'b1;
            state          <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (i_sram_ready) begin
            o_rdata <= i_sram_rdata;
            if (i_request[o_grant]) begin
              o_ready[o_grant] <= 1'b1;
              state            <= ACK;
            end else begin
              // Owner walked away early: finish the SRAM handshake silently.
              o_sram_request <= 1'b0;
              state          <= RELEASE;
            end
          end
        end
        ACK: begin
          if (!i_request[o_grant]) begin
            o_ready        <= '0;
            o_sram_request <= 1'b0;
            state          <= RELEASE;
          end
        end
        RELEASE: begin
          if (!i_sram_ready) begin
            last_grant <= o_grant;
            o_busy     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Round-robin arbiter that shares one SRAM_interface instance between NUM_PORTS requesters, for example the CPU instruction fetch, CPU data and video DMA ports.
- Each upstream port and the downstream port use the same level handshake:
  - The requester holds request until it sees ready.
  - The requester then drops request.
  - The responder holds ready until it sees request drop.
- The arbiter latches the winner's command, runs exactly one downstream transaction, and routes ready and read data back to the winner.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_request  in  NUM_PORTS  per-port request level.
- i_rw  in  NUM_PORTS  per-port direction, 1 = write.
- i_address  in  NUM_PORTS*ADDR_W  per-port address; port k occupies bits [k*ADDR_W +: ADDR_W].
- i_wdata  in  NUM_PORTS*DATA_W  per-port write data.
- o_rdata  out  DATA_W  read data, shared by all ports; valid while the addressed port's o_ready is 1.
- o_ready  out  NUM_PORTS  per-port completion, one-hot or zero.
- o_sram_request  out  1  to SRAM_interface i_request.
- o_sram_rw  out  1  to SRAM_interface i_rw.
- o_sram_address  out  ADDR_W  to SRAM_interface i_address.
- o_sram_wdata  out  DATA_W  to SRAM_interface i_wdata.
- i_sram_rdata  in  DATA_W  from SRAM_interface o_rdata.
- i_sram_ready  in  1  from SRAM_interface o_ready.
- o_grant  out  $clog2(NUM_PORTS)  index of the port currently owning the SRAM (debug).
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, i_reset=0, asynchronous. The following take effect immediately:
  - state = IDLE.
  - All o_* outputs = 0.
  - last_grant = NUM_PORTS-1, so port 0 wins first.
- Reset mid-transaction: the same values apply and the transaction is abandoned. SRAM_interface shares this reset, so no orphan handshake remains.
- All outputs are registered.
- IDLE:
  - If any i_request bit is 1, pick the winner w = first set bit searching from last_grant+1 upward, wrapping at NUM_PORTS.
  - Latch the winner's i_rw, i_address and i_wdata into the o_sram_* registers.
  - Set o_sram_request=1, o_grant=w, state=ACTIVE.
  - Latency: request sampled at edge N gives o_sram_request=1 after edge N.
  - If no request is pending, stay in IDLE.
- ACTIVE:
  - Wait for i_sram_ready=1.
  - On the edge where it is seen:
    - o_rdata <= i_sram_rdata (captured for reads and writes).
    - If i_request[w]=1: o_ready[w] <= 1, state=ACK.
    - If i_request[w]=0 (requester aborted, a protocol violation): o_sram_request <= 0, state=RELEASE, no o_ready pulse.
  - The latched command is held stable throughout; upstream address/data changes are ignored.
- ACK:
  - Hold o_ready[w]=1 until i_request[w]=0.
  - Then o_ready[w] <= 0, o_sram_request <= 0, state=RELEASE.
- RELEASE:
  - Wait for i_sram_ready=0.
  - Then last_grant <= w, o_busy <= 0, state=IDLE.
  - At most one transaction per grant; a port cannot monopolise the SRAM.
- Simultaneous requests: exactly one grant per IDLE visit. Losers keep request high and are served in round-robin order.
- A port re-requesting in the cycle it leaves ACK competes normally. It wins only if no other port is pending.
- Port index out of range never occurs: w is always taken from a set bit.
- o_rdata keeps its last value until the next capture.

Decomposition:
- Package sram_arbiter_pkg contains:
  - state_t enum: IDLE, ACTIVE, ACK, RELEASE.
  - Localparams for default ADDR_W and DATA_W.
- Sub-module rr_select, combinational:
  - Inputs: request vector and last_grant.
  - Outputs: valid flag and winner index.
  - Implemented as a double-width masked priority encoder.
  - Reusable by future arbiters (SDRAM, bus bridge).

Test Plan:
- Single port 0 writes 0xcafebabe to address 0x0, then reads 0x0. Required:
  - o_sram_request rises 1 cycle after i_request.
  - o_ready[0] is asserted with o_rdata=0xcafebabe.
  - o_ready[1] stays 0.
- Ports 0 and 1 request in the same cycle from reset; port 0 writes 0x4=0xdeadbeef and port 1 reads 0x0. Required: port 0 is granted first; port 1 follows after RELEASE and reads 0xcafebabe.
- Both ports hold requests continuously for 8 transactions. Required: grants alternate 0,1,0,1…; o_grant matches; no back-to-back grant to the same port.
- Port 1 changes i_address from 0x0 to 0x4 during ACTIVE. Required: o_sram_address stays 0x0 and data read equals the 0x0 contents.
- Port 0 drops i_request before i_sram_ready. Required:
  - No o_ready[0] pulse.
  - o_sram_request drops the edge after i_sram_ready.
  - The arbiter returns to IDLE and serves pending port 1 next.
- Assert i_reset=0 during ACTIVE, then release. Required:
  - All outputs read 0 immediately.
  - After release, the first grant goes to port 0 when both ports request.
